// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb
//  Purpose  : Architectural register file plus commit tracker at the tail of
//             the MEM/WB pipeline register. It provides two combinational read
//             ports with write-through bypass for decode, and guarantees
//             exactly one commit per WB instruction even while the pipeline is
//             frozen. A registered commit trace and a retired-instruction
//             counter feed the difftest/trace compare.
//
//  Ports    : clk, rst_n                - clock, async active-low reset
//             stop                      - pipeline freeze (MEM/WB held)
//             wb_have_inst, wb_we,
//             wb_wr, wb_wd, wb_pc       - write-back bundle
//             rs1_addr/rs1_data,
//             rs2_addr/rs2_data         - decode read ports (combinational)
//             debug_commit, debug_wb_*  - registered commit trace
//             retire_cnt                - committed instruction count
//
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop,
    input  logic              wb_have_inst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic [31:0]       wb_pc,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              debug_commit,
    output logic [31:0]       debug_wb_pc,
    output logic              debug_wb_rf_we,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
    output logic [31:0]       retire_cnt
);

    localparam int              c_NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;

    // ------------------------------------------------------------------------
    // Commit tracking. ST_DONE means the instruction currently parked in WB
    // has already committed during this freeze, so it must not write, trace
    // or count again until stop drops.
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_commit;
    logic w_wr_fire;

    assign w_commit  = wb_have_inst && (r_state == ST_OPEN);
    assign w_wr_fire = w_commit && wb_we && (wb_wr != c_ZERO_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The flag only survives while frozen; any unfrozen cycle reopens the
    // WB slot because MEM/WB will have advanced.
    always_comb begin
        w_state_nxt = ST_OPEN;
        if (stop && ((r_state == ST_DONE) || w_commit)) begin
            w_state_nxt = ST_DONE;
        end
    end

    // ------------------------------------------------------------------------
    // Register storage. Each architectural register is its own flop bank so
    // every element has a single driver; index 0 is a constant zero.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_regs [c_NUM_REGS];

    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < c_NUM_REGS; gi++) begin : g_regs
            logic [DATA_W-1:0] r_q;
            logic              w_sel;

            assign w_sel = w_wr_fire && (wb_wr == ADDR_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_sel) begin
                    r_q <= wb_wd;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read ports with write-through bypass: a write landing this cycle is
    // visible to decode immediately, not one cycle later.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;

    always_comb begin
        w_rs1_data = '0;
        if (rs1_addr != c_ZERO_IDX) begin
            if (w_wr_fire && (wb_wr == rs1_addr)) begin
                w_rs1_data = wb_wd;
            end else begin
                w_rs1_data = w_regs[rs1_addr];
            end
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (rs2_addr != c_ZERO_IDX) begin
            if (w_wr_fire && (wb_wr == rs2_addr)) begin
                w_rs2_data = wb_wd;
            end else begin
                w_rs2_data = w_regs[rs2_addr];
            end
        end
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;

    // ------------------------------------------------------------------------
    // Commit trace and retire counter. Trace fields hold their last committed
    // values; only the valid pulse returns to zero between commits.
    // ------------------------------------------------------------------------
    logic              r_debug_commit;
    logic [31:0]       r_debug_wb_pc;
    logic              r_debug_wb_rf_we;
    logic [ADDR_W-1:0] r_debug_wb_rf_wnum;
    logic [DATA_W-1:0] r_debug_wb_rf_wdata;
    logic [31:0]       r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_debug_commit      <= 1'b0;
            r_debug_wb_pc       <= '0;
            r_debug_wb_rf_we    <= 1'b0;
            r_debug_wb_rf_wnum  <= '0;
            r_debug_wb_rf_wdata <= '0;
            r_retire_cnt        <= '0;
        end else begin
            r_debug_commit <= w_commit;
            if (w_commit) begin
                r_debug_wb_pc       <= wb_pc;
                r_debug_wb_rf_we    <= wb_we && (wb_wr != c_ZERO_IDX);
                r_debug_wb_rf_wnum  <= wb_wr;
                r_debug_wb_rf_wdata <= wb_wd;
                // Free-running wrap; no overflow indication is wanted.
                r_retire_cnt        <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign debug_commit      = r_debug_commit;
    assign debug_wb_pc       = r_debug_wb_pc;
    assign debug_wb_rf_we    = r_debug_wb_rf_we;
    assign debug_wb_rf_wnum  = r_debug_wb_rf_wnum;
    assign debug_wb_rf_wdata = r_debug_wb_rf_wdata;
    assign retire_cnt        = r_retire_cnt;

endmodule
`default_nettype wire
